mem_rw_arbiter: RTL and testbench
=================================

// Module: mem_rw_arbiter
// PURPOSE
//  Parametrised successor to the single-channel read/write strobe decode. Arbitrates NUM_CH requesters
//  (round-robin) onto one asynchronous-SRAM-style port. Generates mem_cs/mem_oe/mem_we with setup and
//  programmable wait states, and returns a per-channel completion pulse. Sits between pipeline memory
//  stages (IF/MEM) and the data/instruction memory model.
// PARAMETERS
//  NUM_CH    2   number of requesting channels (1..8)
//  ADDR_W    32  address width
//  DATA_W    32  data width
//  WAIT_CYC  1   strobe-active cycles per access (>=1)
// PORTS
//  clk          in   1               rising-edge clock
//  reset        in   1               asynchronous, active-high reset
//  req_valid    in   NUM_CH          per-channel request
//  req_write    in   NUM_CH          1=write, 0=read
//  req_addr     in   NUM_CH*ADDR_W   packed, ch0 in LSBs
//  req_wdata    in   NUM_CH*DATA_W   packed, ch0 in LSBs
//  req_ready    out  NUM_CH          one-hot accept pulse
//  rsp_valid    out  NUM_CH          one-hot completion pulse
//  rsp_rdata    out  DATA_W          read data, valid with rsp_valid of a read
//  mem_cs       out  1               chip select
//  mem_oe       out  1               output enable (read strobe)
//  mem_we       out  1               write enable (write strobe)
//  mem_addr     out  ADDR_W          latched address
//  mem_wdata    out  DATA_W          latched write data
//  mem_rdata    in   DATA_W          memory read data
// BEHAVIOUR
//  - Reset (async): FSM=IDLE, rr_ptr=0, all outputs 0 (req_ready, rsp_valid, cs/oe/we, addr, wdata, rdata).
//    Reset mid-access aborts it: strobes drop immediately, no rsp_valid is issued.
//  - FSM: IDLE -> SETUP -> ACCESS (WAIT_CYC cycles) -> DONE -> IDLE [-> TURN, see CONFIGURATION].
//  - IDLE: if any req_valid, pick winner = first set bit at/after rr_ptr (wrapping); pulse req_ready[winner]
//    for that cycle (cycle T); latch ch index, write, addr, wdata; rr_ptr <= (winner+1) mod NUM_CH.
//    req_ready is only ever asserted in IDLE, at most one bit.
//  - SETUP (T+1): mem_cs=1, mem_addr/mem_wdata driven, oe=we=0.
//  - ACCESS (T+2 .. T+1+WAIT_CYC): mem_cs=1, mem_oe=~write, mem_we=write. Down-counter of width
//    $clog2(WAIT_CYC+1). mem_rdata captured on the last ACCESS cycle edge.
//  - DONE (T+2+WAIT_CYC): cs/oe/we=0; rsp_valid[ch]=1 for one cycle; rsp_rdata holds capture until next read.
//  - Invariant: mem_oe & mem_we never both 1; neither is ever 1 without mem_cs.
//  - Requester holds req_* stable until req_ready; afterwards may change freely (block uses latched copies).
//  - req_valid dropped before grant: ignored, no side effect. New requests during a transaction wait.
//  - Latency: accept to rsp_valid = WAIT_CYC+2 cycles; min issue interval WAIT_CYC+3 cycles.
// CONFIGURATION
//  - MEM_TURNAROUND_EN defined: when the accepted access direction differs from the previous completed
//    access, FSM goes IDLE-accept -> TURN (1 idle cycle, cs=0) -> SETUP; latency +1 for that access only.
//    Direction history resets to "read".
//  - Undefined: TURN state absent; timing exactly as in BEHAVIOUR.
// STRUCTURE
//  - Shared package mem_pkg: FSM state enum (IDLE, SETUP, ACCESS, DONE, TURN), access-direction constants
//    RD=0/WR=1.
//  - One sub-module: rr_arbiter (NUM_CH; inputs req, ptr; output one-hot grant + index), combinational.
//  - Final strobe decode kept as cs&oe / cs&we form for compatibility with existing memory models.
// TESTING
//  1. Reset: reset=1 mid-ACCESS of write -> mem_we/mem_cs 0 same cycle, no rsp_valid, rr_ptr=0 after release.
//  2. Single read ch0 addr 0x100, WAIT_CYC=1, mem_rdata=0xDEADBEEF -> req_ready[0] at T, oe at T+2,
//     rsp_valid[0] at T+3 with rsp_rdata=0xDEADBEEF.
//  3. Write ch1 addr 0x40 data 0x12345678, WAIT_CYC=3 -> we high exactly 3 cycles, mem_wdata=0x12345678,
//     rsp_valid[1] at T+5, oe never high.
//  4. NUM_CH=2, both valid continuously for 4 grants -> grant order 0,1,0,1; never two req_ready bits set.
//  5. MEM_TURNAROUND_EN: read then write back-to-back -> one cs=0 cycle between accept and SETUP of write;
//     read then read -> no extra cycle.
//  6. Assertion run with random req traffic 10k cycles -> no oe&we, no strobe without cs, every accept
//     followed by exactly one rsp_valid on same channel.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory read/write arbiter: FSM states, access
// direction constants and a small round-robin pointer helper.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_TURN   = 3'd4
  } state_e;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  // Next round-robin position after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return ((idx + 32'sd1) >= n) ? 32'sd0 : (idx + 32'sd1);
  endfunction

endpackage

// File: rtl/mem_rw_arbiter_if.sv
// Request/response and SRAM-port bundle for mem_rw_arbiter.
// slave  : the arbiter side; master : requesters plus memory model side.
interface mem_rw_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_write;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH-1:0]        rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata;
  logic                     mem_cs;
  logic                     mem_oe;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_cs, mem_oe, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_cs, mem_oe, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after
// i_ptr (wrapping) wins; returns one-hot grant, its index and an any flag.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_grant,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_any
);

  // Two passes: channels at/above the pointer first, then the wrapped ones.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!o_any && i_req[i] && (i >= int'(i_ptr))) begin
        o_any      = 1'b1;
        o_grant[i] = 1'b1;
        o_idx      = IDX_W'(i);
      end else begin
        o_any = o_any;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!o_any && i_req[i] && (i < int'(i_ptr))) begin
        o_any      = 1'b1;
        o_grant[i] = 1'b1;
        o_idx      = IDX_W'(i);
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/mem_rw_arbiter.sv
// mem_rw_arbiter: round-robin arbitration of NUM_CH requesters onto one
// asynchronous-SRAM-style port (cs/oe/we with a setup cycle and WAIT_CYC
// strobe cycles), returning a one-cycle completion pulse per channel.
// Optional macro MEM_TURNAROUND_EN inserts one idle cycle (cs=0) before
// SETUP whenever the access direction changes from the last completed one.
module mem_rw_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  mem_rw_arbiter_if.slave   bus
);
  import mem_pkg::*;

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(WAIT_CYC + 1);

  state_e              r_state;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [NUM_CH-1:0]   r_ch_oh;
  logic                r_write;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_CH-1:0]   r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_mem_cs;
  logic                r_mem_oe;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
`ifdef MEM_TURNAROUND_EN
  logic                r_last_dir;
  logic                w_turn;
`endif

  logic [NUM_CH-1:0]   w_grant;
  logic [IDX_W-1:0]    w_idx;
  logic                w_any;
  logic                w_sel_write;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_rr (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // One-hot mux of the winning channel's request fields.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sel_write = w_sel_write | (w_grant[i] & bus.req_write[i]);
      w_sel_addr  = w_sel_addr  | ({ADDR_W{w_grant[i]}} & bus.req_addr[i*ADDR_W +: ADDR_W]);
      w_sel_wdata = w_sel_wdata | ({DATA_W{w_grant[i]}} & bus.req_wdata[i*DATA_W +: DATA_W]);
    end
  end

`ifdef MEM_TURNAROUND_EN
  assign w_turn = (w_sel_write != r_last_dir);
`endif

  // Access sequencer: accept, setup, strobe wait states, completion pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_ch_oh     <= '0;
      r_write     <= RD;
      r_cnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_mem_cs    <= 1'b0;
      r_mem_oe    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef MEM_TURNAROUND_EN
      r_last_dir  <= RD;
`endif
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_ch_oh     <= w_grant;
            r_write     <= w_sel_write;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_rr_ptr    <= IDX_W'(wrap_inc(int'(w_idx), NUM_CH));
`ifdef MEM_TURNAROUND_EN
            if (w_turn) begin
              r_state  <= ST_TURN;
              r_mem_cs <= 1'b0;
            end else begin
              r_state  <= ST_SETUP;
              r_mem_cs <= 1'b1;
            end
`else
            r_state  <= ST_SETUP;
            r_mem_cs <= 1'b1;
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
`ifdef MEM_TURNAROUND_EN
        ST_TURN: begin
          r_state  <= ST_SETUP;
          r_mem_cs <= 1'b1;
        end
`endif
        ST_SETUP: begin
          r_state  <= ST_ACCESS;
          r_mem_oe <= ~r_write;
          r_mem_we <= r_write;
          r_cnt    <= CNT_W'(WAIT_CYC);
        end
        ST_ACCESS: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state     <= ST_DONE;
            r_mem_cs    <= 1'b0;
            r_mem_oe    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_rsp_valid <= r_ch_oh;
            if (r_write == RD) begin
              r_rsp_rdata <= bus.mem_rdata;
            end else begin
              r_rsp_rdata <= r_rsp_rdata;
            end
`ifdef MEM_TURNAROUND_EN
            r_last_dir  <= r_write;
`endif
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_mem_cs <= 1'b0;
          r_mem_oe <= 1'b0;
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Accept pulse is only offered while idle and out of reset.
  assign bus.req_ready = ((r_state == ST_IDLE) && !i_reset) ? w_grant : '0;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.mem_cs    = r_mem_cs;
  // Strobes are qualified by chip select so the memory model sees cs&oe / cs&we.
  assign bus.mem_oe    = r_mem_cs & r_mem_oe;
  assign bus.mem_we    = r_mem_cs & r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_rw_arbiter.sv
// Self-checking bench for mem_rw_arbiter: a cycle-window transaction model
// predicts every output each cycle; directed scenarios pin latencies and data.
module tb_mem_rw_arbiter;

  localparam int NUM_CH   = 2;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int WAIT_CYC = 3;
`ifdef MEM_TURNAROUND_EN
  localparam int TA = 1;
`else
  localparam int TA = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_rw_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_rw_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYC(WAIT_CYC)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // requester side
  bit          pend   [NUM_CH];
  bit          p_wr   [NUM_CH];
  logic [31:0] p_addr [NUM_CH];
  logic [31:0] p_wdata[NUM_CH];
  logic [31:0] rdata_drv;

  // behavioural model: one transaction described by its cycle windows
  bit          tv;
  int          t_ch, t_setup, t_acc0, t_accn, t_done, free_at, ptr;
  bit          t_wr, last_wr;
  logic [31:0] m_addr, m_wdata, m_rdata;

  // observations of the DUT for directed literal checks
  int          obs_ready_cyc, obs_rsp_cyc, obs_we_cnt, obs_oe_cnt;
  logic [31:0] obs_rdata, obs_wd;
  logic [1:0]  obs_rsp_mask;
  int          grant_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    tv = 1'b0; free_at = 0; ptr = 0; last_wr = 1'b0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  task automatic obs_clear();
    obs_ready_cyc = -1; obs_rsp_cyc = -1; obs_we_cnt = 0; obs_oe_cnt = 0;
    obs_rdata = '0; obs_wd = '0; obs_rsp_mask = '0;
  endtask

  // One clock cycle: drive, predict, compare, advance the model.
  task automatic step();
    logic [NUM_CH-1:0] e_ready, e_rsp;
    bit e_cs, e_oe, e_we;
    int win, c, ex;
    @(posedge clk); #1;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.req_valid[i] = pend[i];
      bus.req_write[i] = pend[i] ? p_wr[i] : 1'($urandom);
      bus.req_addr[i*ADDR_W +: ADDR_W]  = pend[i] ? p_addr[i]  : $urandom;
      bus.req_wdata[i*DATA_W +: DATA_W] = pend[i] ? p_wdata[i] : $urandom;
    end
    bus.mem_rdata = rdata_drv;
    #3;
    if (rst) begin
      model_reset();
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_strobes", {bus.mem_cs, bus.mem_oe, bus.mem_we}, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      chk("rst_rdata", bus.rsp_rdata, 0);
    end else begin
      win = -1;
      if (cyc >= free_at) begin
        for (int k = 0; k < NUM_CH; k++) begin
          c = (ptr + k) % NUM_CH;
          if (win < 0 && pend[c]) win = c;
        end
      end
      e_ready = '0;
      if (win >= 0) e_ready[win] = 1'b1;
      e_cs  = tv && cyc >= t_setup && cyc <= t_accn;
      e_oe  = tv && cyc >= t_acc0 && cyc <= t_accn && !t_wr;
      e_we  = tv && cyc >= t_acc0 && cyc <= t_accn && t_wr;
      e_rsp = '0;
      if (tv && cyc == t_done) e_rsp[t_ch] = 1'b1;
      chk("req_ready", bus.req_ready, e_ready);
      chk("rsp_valid", bus.rsp_valid, e_rsp);
      chk("mem_cs", bus.mem_cs, e_cs);
      chk("mem_oe", bus.mem_oe, e_oe);
      chk("mem_we", bus.mem_we, e_we);
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("rsp_rdata", bus.rsp_rdata, m_rdata);
      chk("oe_and_we", bus.mem_oe & bus.mem_we, 0);
      chk("strobe_wo_cs", (bus.mem_oe | bus.mem_we) & ~bus.mem_cs, 0);
      chk("ready_onehot", $countones(bus.req_ready) > 1, 0);
      // model advance for the next cycle
      if (tv && cyc == t_accn && !t_wr) m_rdata = rdata_drv;
      if (win >= 0) begin
        ex      = (TA != 0 && p_wr[win] != last_wr) ? 1 : 0;
        tv      = 1'b1;
        t_ch    = win;
        t_wr    = p_wr[win];
        t_setup = cyc + 1 + ex;
        t_acc0  = cyc + 2 + ex;
        t_accn  = cyc + 1 + ex + WAIT_CYC;
        t_done  = t_accn + 1;
        free_at = t_done + 1;
        last_wr = p_wr[win];
        m_addr  = p_addr[win];
        m_wdata = p_wdata[win];
        ptr     = (win + 1) % NUM_CH;
        pend[win] = 1'b0;
      end
    end
    // DUT observations
    if (bus.req_ready != 0) begin
      if (obs_ready_cyc < 0) obs_ready_cyc = cyc;
      for (int i = 0; i < NUM_CH; i++) if (bus.req_ready[i]) grant_log.push_back(i);
    end
    if (bus.rsp_valid != 0 && obs_rsp_cyc < 0) begin
      obs_rsp_cyc = cyc; obs_rdata = bus.rsp_rdata; obs_rsp_mask = bus.rsp_valid;
    end
    if (bus.mem_we) begin obs_we_cnt++; obs_wd = bus.mem_wdata; end
    if (bus.mem_oe) obs_oe_cnt++;
    cyc++;
  endtask

  task automatic request(input int ch, input bit wr, input logic [31:0] a, input logic [31:0] d);
    pend[ch] = 1'b1; p_wr[ch] = wr; p_addr[ch] = a; p_wdata[ch] = d;
  endtask

  task automatic run_to_rsp(input string nm);
    int n;
    obs_clear();
    n = 0;
    while (obs_rsp_cyc < 0 && n < 40) begin step(); n++; end
    if (obs_rsp_cyc < 0) chk({nm, "_timeout"}, 0, 1);
    step(); // let DONE retire
  endtask

  initial begin
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_rdata = '0; rdata_drv = '0;
    for (int i = 0; i < NUM_CH; i++) begin pend[i] = 1'b0; p_wr[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0; end
    model_reset();
    obs_clear();

    // reset state
    step(); step();
    rst = 1'b0;
    step();

    // single read ch0
    rdata_drv = 32'hDEADBEEF;
    request(0, 1'b0, 32'h0000_0100, 32'h0);
    run_to_rsp("rd");
    chk("rd_latency", obs_rsp_cyc - obs_ready_cyc, WAIT_CYC + 2);
    chk("rd_rdata", obs_rdata, 32'hDEADBEEF);
    chk("rd_rsp_ch", obs_rsp_mask, 2'b01);
    chk("rd_oe_cycles", obs_oe_cnt, WAIT_CYC);

    // single write ch1
    rdata_drv = 32'hA5A5_5A5A;
    request(1, 1'b1, 32'h0000_0040, 32'h1234_5678);
    run_to_rsp("wr");
    chk("wr_latency", obs_rsp_cyc - obs_ready_cyc, 5 + TA);
    chk("wr_we_cycles", obs_we_cnt, 3);
    chk("wr_oe_cycles", obs_oe_cnt, 0);
    chk("wr_wdata", obs_wd, 32'h1234_5678);
    chk("wr_rsp_ch", obs_rsp_mask, 2'b10);
    chk("wr_keeps_rdata", bus.rsp_rdata, 32'hDEADBEEF);

    // read after write, then read after read
    request(0, 1'b0, 32'h0000_0200, 32'h0);
    run_to_rsp("rw_turn");
    chk("rd_after_wr_latency", obs_rsp_cyc - obs_ready_cyc, 5 + TA);
    request(0, 1'b0, 32'h0000_0204, 32'h0);
    run_to_rsp("rr");
    chk("rd_after_rd_latency", obs_rsp_cyc - obs_ready_cyc, 5);

    // reset in the middle of a write strobe
    request(1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D);
    obs_clear();
    for (int n = 0; n < 20 && obs_we_cnt == 0; n++) step();
    chk("abort_saw_we", obs_we_cnt > 0, 1);
    rst = 1'b1;
    #1;
    chk("abort_we_drop", bus.mem_we, 0);
    chk("abort_cs_drop", bus.mem_cs, 0);
    step(); step();
    rst = 1'b0;
    obs_clear();
    for (int n = 0; n < 8; n++) step();
    chk("abort_no_rsp", obs_rsp_cyc, -1);

    // two channels requesting continuously: alternating grants from ptr 0
    grant_log.delete();
    request(0, 1'b0, $urandom, 32'h0);
    request(1, 1'b0, $urandom, 32'h0);
    for (int n = 0; n < 60 && grant_log.size() < 4; n++) begin
      step();
      for (int i = 0; i < NUM_CH; i++) if (!pend[i]) request(i, 1'b0, $urandom, 32'h0);
    end
    chk("rr_grant_count", grant_log.size() >= 4, 1);
    for (int k = 0; k < 4; k++) chk("rr_grant_order", (k < grant_log.size()) ? grant_log[k] : 99, k % 2);
    for (int i = 0; i < NUM_CH; i++) pend[i] = 1'b0;
    for (int n = 0; n < 10; n++) step();

    // randomized traffic
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (pend[i] && ($urandom % 16) == 0) pend[i] = 1'b0;
        else if (!pend[i] && ($urandom % 3) == 0) request(i, 1'($urandom), $urandom, $urandom);
      end
      rdata_drv = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
